fetch_unit: RTL and testbench

Parametrised instruction-fetch stage for the FDE CPU. Holds the program counter, issues word reads to an external synchronous instruction memory (1-cycle read latency), and presents fetched instructions with their PC to decode over a valid/ready handshake. Decode can stall the stream, and a later stage can redirect the PC at any time, flushing any stale fetches. Addresses wrap modulo 2^ADDR_W.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_skid_buf.sv | 51 +++++
 rtl/fetch_unit.sv | 71 +++++++
 tb/tb_fetch_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and the buffered-entry type for the instruction-fetch stage.
package fetch_pkg;
    localparam int FETCH_ADDR_W   = 12;
    localparam int FETCH_DATA_W   = 32;
    localparam int FETCH_RESET_PC = 0;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: circular FIFO between imem responses and decode.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       push,
    input  entry_t                     push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output entry_t                     head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          pop_ok;

    assign pop_ok = pop & (count != '0);
    assign head   = mem[rd_ptr];

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Flush wins over push, and a pop in the flush cycle is absorbed by the clear.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop_ok) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, in-flight tracking and issue control in front of the skid buffer.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = FETCH_ADDR_W,
    parameter int DATA_W    = FETCH_DATA_W,
    parameter int RESET_PC  = FETCH_RESET_PC,
    parameter int BUF_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [DATA_W-1:0] i_imem_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_instruction,
    output logic [ADDR_W-1:0] o_pc,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_target
);
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, inflight_pc;
    logic              inflight_q, pop;
    logic [CW-1:0]     count;
    entry_t            head, resp;

    assign o_valid       = count != '0;
    assign pop           = o_valid & i_ready;
    assign o_imem_addr   = pc_q;
    assign o_pc          = head.pc;
    assign o_instruction = head.instr;
    assign resp          = '{pc: inflight_pc, instr: i_imem_data};

    // Counting the in-flight slot and this cycle's pop keeps a full buffer streaming without overflow.
    assign o_imem_req = i_reset & ~i_redirect &
                        (int'(count) + int'(inflight_q) - int'(pop) < BUF_DEPTH);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            pc_q        <= ADDR_W'(RESET_PC);
            inflight_q  <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight_q  <= o_imem_req;
            inflight_pc <= pc_q;
            pc_q        <= i_redirect ? i_target : pc_q + ADDR_W'(o_imem_req);
        end
    end

    // A redirect flushes the buffer, which also drops the response of any in-flight request.
    fetch_skid_buf #(
        .DEPTH   (BUF_DEPTH),
        .entry_t (entry_t)
    ) u_buf (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .push      (inflight_q),
        .push_data (resp),
        .pop       (pop),
        .flush     (i_redirect),
        .count     (count),
        .head      (head)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a registered-read word memory.
module tb_fetch_unit;
    localparam int AW    = 12;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0, rst_n = 1'b0, ready = 1'b1, redirect = 1'b0;
    logic [AW-1:0] target = '0;
    logic          req, valid, w_req, w_valid;
    logic [AW-1:0] addr, pc, w_addr, w_pc;
    logic [DW-1:0] rdata, instr, w_rdata, w_instr;
    logic [DW-1:0] mem [1<<AW];

    int checks = 0, failures = 0;
    int since = 0, wcyc = -1;
    logic [AW-1:0]    target_q [$];
    logic [AW+DW-1:0] exp_q [$];
    logic [AW-1:0]    issue_pc = '0;

    always #5 clk = ~clk;

    initial for (int k = 0; k < (1 << AW); k++) mem[k] = 32'h1000_0000 + k;

    always @(posedge clk) if (req)   rdata   <= mem[addr];
    always @(posedge clk) if (w_req) w_rdata <= mem[w_addr];

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0), .BUF_DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_reset(rst_n), .o_imem_req(req), .o_imem_addr(addr),
        .i_imem_data(rdata), .o_valid(valid), .i_ready(ready), .o_instruction(instr),
        .o_pc(pc), .i_redirect(redirect), .i_target(target)
    );

    fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(12'hFFE), .BUF_DEPTH(DEPTH)) dut_wrap (
        .i_clk(clk), .i_reset(rst_n), .o_imem_req(w_req), .o_imem_addr(w_addr),
        .i_imem_data(w_rdata), .o_valid(w_valid), .i_ready(1'b1), .o_instruction(w_instr),
        .o_pc(w_pc), .i_redirect(1'b0), .i_target(12'h000)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: fetches form a contiguous address stream per segment, restarted by reset or redirect.
    always @(negedge clk) begin
        bit pop, exp_req;
        if (!rst_n) begin
            chk("rst_valid", valid, 0);
            chk("rst_req", req, 0);
            chk("rst_pc", pc, 0);
            chk("rst_instr", instr, 0);
            chk("rst_addr", addr, 0);
            exp_q.delete();
            issue_pc = '0;
            since    = 0;
        end else begin
            since++;
            pop     = valid && ready;
            exp_req = !redirect && (exp_q.size() - int'(pop) < DEPTH);
            chk("imem_req", req, exp_req);
            if (exp_req) chk("imem_addr", addr, issue_pc);
            if (since <= 2) chk("restart_gap_valid", valid, 0);
            else chk("stream_valid", valid, 1);
            if (valid) begin
                if (exp_q.size() == 0) chk("spurious_valid", valid, 0);
                else begin
                    chk("head_pc", pc, exp_q[0][AW+DW-1:DW]);
                    chk("head_instr", instr, exp_q[0][DW-1:0]);
                end
            end
            if (pop && exp_q.size() != 0) void'(exp_q.pop_front());
            if (exp_req) begin
                exp_q.push_back({issue_pc, mem[issue_pc]});
                issue_pc++;
            end
            if (redirect) begin
                if (target_q.size() == 0) chk("redirect_target", redirect, 0);
                else begin
                    issue_pc = target_q.pop_front();
                    exp_q.delete();
                    since = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [AW-1:0] wexp;
        if (!rst_n) wcyc = -1;
        else begin
            wcyc++;
            if (wcyc >= 2 && wcyc <= 5) begin
                wexp = AW'(12'hFFE + wcyc - 2);
                chk("wrap_valid", w_valid, 1);
                chk("wrap_pc", w_pc, wexp);
                chk("wrap_instr", w_instr, mem[wexp]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [AW-1:0] t);
        redirect = 1'b1;
        target   = t;
        target_q.push_back(t);
        cyc();
        redirect = 1'b0;
    endtask

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        repeat (12) cyc();
        ready = 1'b0;
        repeat (5) cyc();
        ready = 1'b1;
        repeat (6) cyc();
        ready = 1'b0;
        repeat (4) cyc();
        redir(12'h100);
        ready = 1'b1;
        repeat (8) cyc();
        redir(12'h200);
        repeat (6) cyc();
        redir(12'hFFE);
        repeat (8) cyc();
        redir(12'h300);
        redir(12'h400);
        repeat (6) cyc();
        rst_n = 1'b0;
        #1;
        chk("async_valid", valid, 0);
        chk("async_req", req, 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (8) cyc();
        for (int n = 0; n < 3000; n++) begin
            ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 24) == 0) redir(AW'($urandom));
            else cyc();
        end
        ready = 1'b1;
        repeat (5) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
